csr_trap_unit: RTL and testbench

Parametrised machine-mode CSR and trap unit, the successor to the single-op CSR/exception block in the writeback stage. It executes all six Zicsr ops plus ECALL/EBREAK/MRET, and maintains mstatus/mie/mip and 64-bit mcycle/minstret. It takes synchronous exceptions and one external interrupt, and drives the pipeline flush and redirect address.

---
 rtl/csr_trap_unit.sv | 263 ++++++++++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_unit
// Brief    : Machine-mode Zicsr execution, trap entry/return, interrupt
//            gating and 64-bit cycle/instret counters for the writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_unit #(
    parameter int               XLEN       = 32,
    parameter int               ADDR_WIDTH = 32,
    parameter int               EX_WIDTH   = 4,
    parameter logic [XLEN-1:0]  RESET_TVEC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [31:0]           instr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  exception_valid,
    input  logic [EX_WIDTH-1:0]   exception_cause,
    input  logic [XLEN-1:0]       exception_tval,
    input  logic                  irq_ext,
    output logic [4:0]            rd_addr,
    output logic [XLEN-1:0]       rd_data,
    output logic                  rd_enable,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_addr
);

    // CSR addresses
    localparam logic [11:0] c_mstatus   = 12'h300;
    localparam logic [11:0] c_misa      = 12'h301;
    localparam logic [11:0] c_mie       = 12'h304;
    localparam logic [11:0] c_mtvec     = 12'h305;
    localparam logic [11:0] c_mscratch  = 12'h340;
    localparam logic [11:0] c_mepc      = 12'h341;
    localparam logic [11:0] c_mcause    = 12'h342;
    localparam logic [11:0] c_mtval     = 12'h343;
    localparam logic [11:0] c_mip       = 12'h344;
    localparam logic [11:0] c_mcycle    = 12'hB00;
    localparam logic [11:0] c_minstret  = 12'hB02;
    localparam logic [11:0] c_mcycleh   = 12'hB80;
    localparam logic [11:0] c_minstreth = 12'hB82;

    localparam logic [XLEN-1:0] c_misa_val  = 32'h4000_0100;
    localparam logic [XLEN-1:0] c_irq_cause = 32'h8000_000B;
    localparam logic [4:0]      c_opcode    = 5'b11100;

    // Architectural state
    logic            r_mie_bit;      // mstatus.MIE
    logic            r_mpie_bit;     // mstatus.MPIE
    logic            r_meie_bit;     // mie.MEIE
    logic [XLEN-3:0] r_mtvec_base;   // mtvec[XLEN-1:2]
    logic            r_mtvec_vec;    // mtvec mode == 01
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-3:0] r_mepc_hi;      // mepc[XLEN-1:2], low bits read as 0
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [63:0]     r_mcycle;
    logic [63:0]     r_minstret;

    // Decode fields
    logic [2:0]      w_funct3;
    logic [11:0]     w_csr_addr;
    logic [4:0]      w_rs1;
    logic            w_is_system;
    logic            w_is_csr;
    logic            w_is_ecall;
    logic            w_is_ebreak;
    logic            w_is_mret;
    logic            w_csr_write;
    logic [XLEN-1:0] w_src;

    assign w_funct3    = instr[14:12];
    assign w_csr_addr  = instr[31:20];
    assign w_rs1       = instr[19:15];
    assign rd_addr     = instr[11:7];
    assign w_is_system = instr_valid && (instr[6:2] == c_opcode) && (instr[1:0] == 2'b11);
    assign w_is_csr    = w_is_system && (w_funct3[1:0] != 2'b00);
    assign w_is_ecall  = w_is_system && (w_funct3 == 3'b000) && (w_csr_addr == 12'h000);
    assign w_is_ebreak = w_is_system && (w_funct3 == 3'b000) && (w_csr_addr == 12'h001);
    assign w_is_mret   = w_is_system && (w_funct3 == 3'b000) && (w_csr_addr == 12'h302);
    // RS/RC with a zero source field are pure reads; RW always writes
    assign w_csr_write = (w_funct3[1:0] == 2'b01) || (w_rs1 != 5'd0);
    assign w_src       = w_funct3[2] ? {{(XLEN-5){1'b0}}, w_rs1} : wr_data;

    // Read-back views with hardwired fields applied
    logic [XLEN-1:0] w_mstatus_rd;
    logic [XLEN-1:0] w_mie_rd;
    logic [XLEN-1:0] w_mip_rd;
    logic [XLEN-1:0] w_mtvec_rd;
    logic [XLEN-1:0] w_mepc_rd;
    logic [XLEN-1:0] w_tvec_base;

    assign w_mtvec_rd  = {r_mtvec_base, 1'b0, r_mtvec_vec};
    assign w_tvec_base = {r_mtvec_base, 2'b00};
    assign w_mepc_rd   = {r_mepc_hi, 2'b00};

    // Build status/enable/pending words from their individual bits
    always_comb begin
        w_mstatus_rd        = '0;
        w_mstatus_rd[12:11] = 2'b11;
        w_mstatus_rd[7]     = r_mpie_bit;
        w_mstatus_rd[3]     = r_mie_bit;
        w_mie_rd            = '0;
        w_mie_rd[11]        = r_meie_bit;
        w_mip_rd            = '0;
        w_mip_rd[11]        = irq_ext;
    end

    // CSR read mux; an unlisted address is unimplemented
    logic [XLEN-1:0] w_old;
    logic            w_csr_ok;
    always_comb begin
        w_old    = '0;
        w_csr_ok = 1'b1;
        case (w_csr_addr)
            c_mstatus:   w_old = w_mstatus_rd;
            c_misa:      w_old = c_misa_val;
            c_mie:       w_old = w_mie_rd;
            c_mip:       w_old = w_mip_rd;
            c_mtvec:     w_old = w_mtvec_rd;
            c_mscratch:  w_old = r_mscratch;
            c_mepc:      w_old = w_mepc_rd;
            c_mcause:    w_old = r_mcause;
            c_mtval:     w_old = r_mtval;
            c_mcycle:    w_old = r_mcycle[31:0];
            c_mcycleh:   w_old = r_mcycle[63:32];
            c_minstret:  w_old = r_minstret[31:0];
            c_minstreth: w_old = r_minstret[63:32];
            default:     w_csr_ok = 1'b0;
        endcase
    end

    // New CSR value from the op kind
    logic [XLEN-1:0] w_wv;
    always_comb begin
        case (w_funct3[1:0])
            2'b01:   w_wv = w_src;
            2'b10:   w_wv = w_old | w_src;
            default: w_wv = w_old & ~w_src;
        endcase
    end

    // Trap qualification in priority order
    logic w_ro_target;
    logic w_illegal;
    logic w_exc;
    logic w_env;
    logic w_irq;
    logic w_trap;
    logic w_mret;
    logic w_wr_en;

    assign w_ro_target = (w_csr_addr == c_misa) || (w_csr_addr == c_mip) ||
                         (w_csr_addr[11:10] == 2'b11);
    assign w_exc       = instr_valid && exception_valid;
    assign w_illegal   = !w_exc && w_is_csr && (!w_csr_ok || (w_csr_write && w_ro_target));
    assign w_env       = !w_exc && !w_illegal && (w_is_ecall || w_is_ebreak);
    assign w_irq       = instr_valid && !w_exc && !w_illegal && !w_env &&
                         r_mie_bit && r_meie_bit && irq_ext;
    assign w_trap      = w_exc || w_illegal || w_env || w_irq;
    assign w_mret      = w_is_mret && !w_trap;
    assign w_wr_en     = w_is_csr && w_csr_write && !w_trap;

    // Cause and tval recorded at trap entry
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_tval;
    always_comb begin
        w_cause = '0;
        w_tval  = '0;
        if (w_exc) begin
            w_cause = XLEN'(exception_cause);
            w_tval  = exception_tval;
        end else if (w_illegal) begin
            w_cause = XLEN'(2);
            w_tval  = XLEN'(instr);
        end else if (w_is_ecall && w_env) begin
            w_cause = XLEN'(11);
        end else if (w_env) begin
            w_cause = XLEN'(3);
            w_tval  = XLEN'(pc);
        end else if (w_irq) begin
            w_cause = c_irq_cause;
        end
    end

    // Redirect target and writeback outputs
    always_comb begin
        flush      = w_trap || w_mret;
        flush_addr = '0;
        if (w_irq && r_mtvec_vec)
            flush_addr = ADDR_WIDTH'(w_tvec_base + XLEN'(44));
        else if (w_trap)
            flush_addr = ADDR_WIDTH'(w_tvec_base);
        else if (w_mret)
            flush_addr = ADDR_WIDTH'(w_mepc_rd);
        rd_data    = (w_is_csr && w_csr_ok) ? w_old : '0;
        rd_enable  = w_is_csr && !w_trap && (rd_addr != 5'd0);
    end

    // Counter next values; an explicit write replaces only its own half
    logic [63:0] w_mcycle_nxt;
    logic [63:0] w_minstret_nxt;
    always_comb begin
        w_mcycle_nxt   = r_mcycle + 64'd1;
        w_minstret_nxt = r_minstret + {63'd0, (instr_valid && !w_trap)};
        if (w_wr_en && (w_csr_addr == c_mcycle))    w_mcycle_nxt[31:0]    = w_wv[31:0];
        if (w_wr_en && (w_csr_addr == c_mcycleh))   w_mcycle_nxt[63:32]   = w_wv[31:0];
        if (w_wr_en && (w_csr_addr == c_minstret))  w_minstret_nxt[31:0]  = w_wv[31:0];
        if (w_wr_en && (w_csr_addr == c_minstreth)) w_minstret_nxt[63:32] = w_wv[31:0];
    end

    // CSR state update: reset, then trap entry, MRET, or explicit write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mie_bit    <= 1'b0;
            r_mpie_bit   <= 1'b0;
            r_meie_bit   <= 1'b0;
            r_mtvec_base <= RESET_TVEC[XLEN-1:2];
            r_mtvec_vec  <= (RESET_TVEC[1:0] == 2'b01);
            r_mscratch   <= '0;
            r_mepc_hi    <= '0;
            r_mcause     <= '0;
            r_mtval      <= '0;
            r_mcycle     <= '0;
            r_minstret   <= '0;
        end else begin
            r_mcycle   <= w_mcycle_nxt;
            r_minstret <= w_minstret_nxt;
            if (w_trap) begin
                r_mepc_hi  <= pc[ADDR_WIDTH-1:2];
                r_mcause   <= w_cause;
                r_mtval    <= w_tval;
                r_mpie_bit <= r_mie_bit;
                r_mie_bit  <= 1'b0;
            end else if (w_mret) begin
                r_mie_bit  <= r_mpie_bit;
                r_mpie_bit <= 1'b1;
            end else if (w_wr_en) begin
                case (w_csr_addr)
                    c_mstatus: begin
                        r_mie_bit  <= w_wv[3];
                        r_mpie_bit <= w_wv[7];
                    end
                    c_mie:      r_meie_bit <= w_wv[11];
                    c_mtvec: begin
                        r_mtvec_base <= w_wv[XLEN-1:2];
                        r_mtvec_vec  <= (w_wv[1:0] == 2'b01);
                    end
                    c_mscratch: r_mscratch <= w_wv;
                    c_mepc:     r_mepc_hi  <= w_wv[XLEN-1:2];
                    c_mcause:   r_mcause   <= w_wv;
                    c_mtval:    r_mtval    <= w_wv;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_unit
// Brief    : Directed self-checking bench for csr_trap_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wr_data;
    logic        exception_valid;
    logic [3:0]  exception_cause;
    logic [31:0] exception_tval;
    logic        irq_ext;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_enable;
    logic        flush;
    logic [31:0] flush_addr;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] c_ecall  = 32'h0000_0073;
    localparam logic [31:0] c_mret   = 32'h3020_0073;
    localparam logic [31:0] c_nop    = 32'h0000_0013;

    csr_trap_unit #(
        .XLEN(32), .ADDR_WIDTH(32), .EX_WIDTH(4), .RESET_TVEC(32'h0000_1000)
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .pc(pc),
        .instr(instr), .wr_data(wr_data), .exception_valid(exception_valid),
        .exception_cause(exception_cause), .exception_tval(exception_tval),
        .irq_ext(irq_ext), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_enable(rd_enable), .flush(flush), .flush_addr(flush_addr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] csr_i(input logic [2:0] f3, input logic [11:0] a,
                                          input logic [4:0] rs, input logic [4:0] rd);
        return {a, rs, f3, rd, 7'h73};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1 ns later
    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] wd, input logic ex, input logic [3:0] ca,
                         input logic [31:0] tv, input logic irq);
        @(negedge clk);
        instr_valid     = v;
        instr           = i;
        pc              = p;
        wr_data         = wd;
        exception_valid = ex;
        exception_cause = ca;
        exception_tval  = tv;
        irq_ext         = irq;
        #1;
    endtask

    task automatic op(input logic [31:0] i, input logic [31:0] p, input logic [31:0] wd);
        drive(1'b1, i, p, wd, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        op(csr_i(3'b010, a, 5'd0, 5'd1), 32'h0, 32'd0);
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; pc = '0; instr = '0; wr_data = '0;
        exception_valid = 1'b0; exception_cause = '0; exception_tval = '0; irq_ext = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_flush_addr", flush_addr, 32'd0);
        chk("rst_rd_en", {31'd0, rd_enable}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        rd_chk("rst_mtvec", 12'h305, 32'h0000_1000);
        rd_chk("rst_mstatus", 12'h300, 32'h0000_1800);

        // mscratch write then zero-source read
        op(csr_i(3'b001, 12'h340, 5'd0, 5'd5), 32'h10, 32'hDEAD_BEEF);
        chk("rw_old", rd_data, 32'd0);
        chk("rw_rd_en", {31'd0, rd_enable}, 32'd1);
        chk("rw_rd_addr", {27'd0, rd_addr}, 32'd5);
        op(csr_i(3'b010, 12'h340, 5'd0, 5'd6), 32'h14, 32'hFFFF_FFFF);
        chk("rs0_data", rd_data, 32'hDEAD_BEEF);
        chk("rs0_rd_en", {31'd0, rd_enable}, 32'd1);
        op(csr_i(3'b010, 12'h340, 5'd0, 5'd0), 32'h18, 32'd0);
        chk("rs0_mscratch", rd_data, 32'hDEAD_BEEF);
        chk("rd0_rd_en", {31'd0, rd_enable}, 32'd0);

        // mtvec mode 1x reads back as 00; then ECALL and MRET
        op(csr_i(3'b001, 12'h305, 5'd0, 5'd0), 32'h1C, 32'h0000_0102);
        rd_chk("mtvec_mode10", 12'h305, 32'h0000_0100);
        op(csr_i(3'b110, 12'h300, 5'd8, 5'd0), 32'h20, 32'd0);
        rd_chk("mstatus_mie1", 12'h300, 32'h0000_1808);
        op(c_ecall, 32'h40, 32'd0);
        chk("ecall_flush", {31'd0, flush}, 32'd1);
        chk("ecall_flush_addr", flush_addr, 32'h100);
        rd_chk("ecall_mepc", 12'h341, 32'h40);
        rd_chk("ecall_mcause", 12'h342, 32'd11);
        rd_chk("ecall_mtval", 12'h343, 32'd0);
        rd_chk("ecall_mstatus", 12'h300, 32'h0000_1880);
        op(c_mret, 32'h104, 32'd0);
        chk("mret_flush", {31'd0, flush}, 32'd1);
        chk("mret_flush_addr", flush_addr, 32'h40);
        rd_chk("mret_mstatus", 12'h300, 32'h0000_1888);

        // Write attempt to misa is illegal
        op(csr_i(3'b001, 12'h301, 5'd2, 5'd1), 32'h80, 32'd0);
        chk("ill_flush", {31'd0, flush}, 32'd1);
        chk("ill_flush_addr", flush_addr, 32'h100);
        chk("ill_rd_en", {31'd0, rd_enable}, 32'd0);
        rd_chk("ill_mcause", 12'h342, 32'd2);
        rd_chk("ill_mtval", 12'h343, csr_i(3'b001, 12'h301, 5'd2, 5'd1));
        rd_chk("ill_mepc", 12'h341, 32'h80);
        op(csr_i(3'b010, 12'h301, 5'd0, 5'd1), 32'h84, 32'd0);
        chk("misa_read", rd_data, 32'h4000_0100);
        chk("misa_read_noflush", {31'd0, flush}, 32'd0);
        op(csr_i(3'b010, 12'h7C0, 5'd0, 5'd1), 32'h88, 32'd0);
        chk("unimpl_flush", {31'd0, flush}, 32'd1);

        // Vectored interrupt, then interrupt alongside an exception
        op(csr_i(3'b001, 12'h305, 5'd0, 5'd0), 32'h90, 32'h0000_0201);
        op(csr_i(3'b001, 12'h304, 5'd0, 5'd0), 32'h94, 32'h0000_0800);
        op(csr_i(3'b110, 12'h300, 5'd8, 5'd0), 32'h98, 32'd0);
        rd_chk("mtvec_vec", 12'h305, 32'h0000_0201);
        drive(1'b1, c_nop, 32'h300, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
        chk("irq_flush", {31'd0, flush}, 32'd1);
        chk("irq_flush_addr", flush_addr, 32'h22C);
        rd_chk("irq_mcause", 12'h342, 32'h8000_000B);
        rd_chk("irq_mepc", 12'h341, 32'h300);
        op(csr_i(3'b110, 12'h300, 5'd8, 5'd0), 32'h9C, 32'd0);
        drive(1'b1, c_nop, 32'h310, 32'd0, 1'b1, 4'd5, 32'h1234, 1'b1);
        chk("exc_irq_flush_addr", flush_addr, 32'h200);
        rd_chk("exc_mcause", 12'h342, 32'd5);
        rd_chk("exc_mtval", 12'h343, 32'h1234);
        drive(1'b1, csr_i(3'b010, 12'h344, 5'd0, 5'd1), 32'hA0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1);
        chk("mip_read", rd_data, 32'h0000_0800);
        chk("mip_noflush", {31'd0, flush}, 32'd0);

        // mcycle low-half write and carry into mcycleh
        op(csr_i(3'b001, 12'hB00, 5'd0, 5'd0), 32'hB0, 32'hFFFF_FFFE);
        idle();
        idle();
        rd_chk("mcycleh_carry", 12'hB80, 32'd1);
        rd_chk("mcycle_low", 12'hB00, 32'd1);

        // minstret over 10 instructions with 2 traps
        op(csr_i(3'b001, 12'hB02, 5'd0, 5'd0), 32'hC0, 32'd0);
        op(c_nop, 32'hC4, 32'd0);
        op(c_nop, 32'hC8, 32'd0);
        op(c_ecall, 32'hCC, 32'd0);
        chk("ecall2_flush", {31'd0, flush}, 32'd1);
        op(c_nop, 32'hD0, 32'd0);
        idle();
        op(c_nop, 32'hD4, 32'd0);
        op(c_nop, 32'hD8, 32'd0);
        drive(1'b1, c_nop, 32'hDC, 32'd0, 1'b1, 4'd1, 32'd0, 1'b0);
        op(c_nop, 32'hE0, 32'd0);
        idle();
        op(c_nop, 32'hE4, 32'd0);
        op(c_nop, 32'hE8, 32'd0);
        rd_chk("minstret_mix", 12'hB02, 32'd8);

        // Reset asserted during a trapping cycle
        op(c_ecall, 32'hF0, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        instr_valid = 1'b0;
        rd_chk("post_rst_minstret", 12'hB02, 32'd0);
        chk("post_rst_flush", {31'd0, flush}, 32'd0);
        chk("post_rst_flush_addr", flush_addr, 32'd0);
        rd_chk("post_rst_mcycle", 12'hB00, 32'd1);
        rd_chk("post_rst_mepc", 12'h341, 32'd0);
        rd_chk("post_rst_mcause", 12'h342, 32'd0);
        rd_chk("post_rst_mstatus", 12'h300, 32'h0000_1800);
        rd_chk("post_rst_mtvec", 12'h305, 32'h0000_1000);
        rd_chk("post_rst_mscratch", 12'h340, 32'd0);
        rd_chk("post_rst_mie", 12'h304, 32'd0);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
